// File: rtl/dspi_link.sv
// dspi_link: dual-SPI (2-bit, mode 0) slave link layer.
//
// Brings the pad SS/SCLK/QD_READ into the CLK domain, deserialises incoming
// bit-pairs into bytes and serialises outgoing bytes onto the pads. The memory
// logic behind it sees only byte-level strobes, never SCLK edges.
//
// Ports:
//   CLK, RST_N        system clock, asynchronous active-low reset
//   SS, SCLK          pad chip select (active low) and serial clock, async
//   QD_READ[1:0]      pad input pair, bit 1 is the higher bit of the pair
//   QD_WRITE[1:0]     pad output pair
//   QD_WRITE_ENABLE   pad output enables (both bits identical)
//   RX_DATA/VALID     received byte and its one-cycle strobe
//   RX_FIRST          marks the first byte of a frame
//   TX_EN             level; switch to transmit at the next byte boundary
//   TX_DATA           byte to transmit, sampled the cycle after TX_REQ
//   TX_REQ            one-cycle request for the next TX_DATA
//   BUSY              a frame is in progress
//   FRAME_ERR         sticky: SS rose mid-byte; cleared on the next SS fall
//
// Build option: define DSPI_DUMMY_SLOT_EN to insert a tri-stated turnaround
// byte slot after entering transmit.
//
// state   | meaning
// IDLE    | waiting for an SS fall
// RX      | shifting bit-pairs in on SCLK rise
// TX      | shifting bit-pairs out on SCLK fall

module dspi_link #(
  parameter int SCLK_DIV_MIN = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SS,
  input  logic       SCLK,
  input  logic [1:0] QD_READ,
  output logic [1:0] QD_WRITE,
  output logic [1:0] QD_WRITE_ENABLE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_FIRST,
  input  logic       TX_EN,
  input  logic [7:0] TX_DATA,
  output logic       TX_REQ,
  output logic       BUSY,
  output logic       FRAME_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_TX   = 2'd2;

  // Minimum CLK cycles between successive SCLK strobes.
  localparam logic [7:0] GAP_MIN = 8'(SCLK_DIV_MIN / 2 - 1);

  // Synchronisers: [0] first flop, [1] second, [2] edge-detect history.
  logic [2:0] ss_sync_q, sck_sync_q;
  logic [1:0] qd_s1_q, qd_s2_q;
  logic       ss_fall_q, ss_rise_q, sck_rise_q, sck_fall_q;
  // Masks SS edges while the chain refills after reset, so an SS already
  // low at release does not look like a fresh fall.
  logic [1:0] settle_q;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       first_q, first_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d;
  logic       load_q, load_d;
  logic [1:0] qd_write_q, qd_write_d;
  logic       oe_q, oe_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] rx_byte;
  logic       drive_ok;

`ifdef DSPI_DUMMY_SLOT_EN
  logic dummy_q, dummy_d;
  assign drive_ok = ~dummy_q;
`else
  assign drive_ok = 1'b1;
`endif

  assign rx_byte = {sr_q[5:0], qd_s2_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    first_d     = first_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    tx_req_d    = 1'b0;
    load_d      = tx_req_q;
    qd_write_d  = qd_write_q;
    oe_d        = oe_q;
    frame_err_d = frame_err_q;
`ifdef DSPI_DUMMY_SLOT_EN
    dummy_d     = dummy_q;
`endif
    gap_d = (sck_rise_q || sck_fall_q) ? 8'd0 :
            (gap_q != 8'hff) ? gap_q + 8'd1 : gap_q;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_q) begin
          state_d     = ST_RX;
          cnt_d       = 2'd0;
          first_d     = 1'b1;
          frame_err_d = 1'b0;
        end
      end
      ST_RX: begin
        if (ss_rise_q) begin
          state_d = ST_IDLE;
          if (cnt_q != 2'd0) frame_err_d = 1'b1;
        end else if (sck_rise_q) begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            if (TX_EN) begin
              state_d = ST_TX;
`ifdef DSPI_DUMMY_SLOT_EN
              dummy_d = 1'b1;
`else
              tx_req_d = 1'b1;
`endif
            end
          end
        end
      end
      ST_TX: begin
        if (ss_rise_q) begin
          state_d    = ST_IDLE;
          oe_d       = 1'b0;
          qd_write_d = 2'b00;
          if (cnt_q != 2'd0) frame_err_d = 1'b1;
        end else begin
          if (load_q) sr_d = TX_DATA;
          if (sck_fall_q && drive_ok) begin
            qd_write_d = sr_q[7:6];
            sr_d       = {sr_q[5:0], 2'b00};
            oe_d       = 1'b1;
          end
          if (sck_rise_q) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              tx_req_d = 1'b1;
`ifdef DSPI_DUMMY_SLOT_EN
              dummy_d  = 1'b0;
`endif
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ss_sync_q   <= 3'b111;
      sck_sync_q  <= 3'b000;
      qd_s1_q     <= 2'b00;
      qd_s2_q     <= 2'b00;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      settle_q    <= 2'd3;
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      sr_q        <= 8'h00;
      first_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      load_q      <= 1'b0;
      qd_write_q  <= 2'b00;
      oe_q        <= 1'b0;
      frame_err_q <= 1'b0;
      gap_q       <= 8'd0;
`ifdef DSPI_DUMMY_SLOT_EN
      dummy_q     <= 1'b0;
`endif
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], SS};
      sck_sync_q  <= {sck_sync_q[1:0], SCLK};
      qd_s1_q     <= QD_READ;
      qd_s2_q     <= qd_s1_q;
      ss_fall_q   <= (settle_q == 2'd0) &&  ss_sync_q[2] && !ss_sync_q[1];
      ss_rise_q   <= (settle_q == 2'd0) && !ss_sync_q[2] &&  ss_sync_q[1];
      sck_rise_q  <= !sck_sync_q[2] &&  sck_sync_q[1];
      sck_fall_q  <=  sck_sync_q[2] && !sck_sync_q[1];
      settle_q    <= (settle_q != 2'd0) ? settle_q - 2'd1 : settle_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      first_q     <= first_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
      load_q      <= load_d;
      qd_write_q  <= qd_write_d;
      oe_q        <= oe_d;
      frame_err_q <= frame_err_d;
      gap_q       <= gap_d;
`ifdef DSPI_DUMMY_SLOT_EN
      dummy_q     <= dummy_d;
`endif
    end
  end

  // SCLK faster than CLK/SCLK_DIV_MIN leaves no time for QD_WRITE to settle.
  a_sclk_rate: assert property (@(posedge CLK) disable iff (!RST_N)
    ((sck_rise_q || sck_fall_q) && state_q != ST_IDLE) |-> (gap_q >= GAP_MIN));

  assign QD_WRITE        = qd_write_q;
  assign QD_WRITE_ENABLE = {2{oe_q}};
  assign RX_DATA         = rx_data_q;
  assign RX_VALID        = rx_valid_q;
  assign RX_FIRST        = rx_first_q;
  assign TX_REQ          = tx_req_q;
  assign BUSY            = (state_q != ST_IDLE);
  assign FRAME_ERR       = frame_err_q;

endmodule

// File: tb/tb_dspi_link.sv
// Testbench for dspi_link: directed frames with a scoreboard. Stimulus pushes
// expected RX bytes, TX_REQ cycles and pad pairs; monitors pop and compare.
module tb_dspi_link;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SS = 1'b1;
  logic       SCLK = 1'b0;
  logic [1:0] QD_READ = 2'b00;
  logic [1:0] QD_WRITE;
  logic [1:0] QD_WRITE_ENABLE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_FIRST;
  logic       TX_EN = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_REQ;
  logic       BUSY;
  logic       FRAME_ERR;

  dspi_link #(.SCLK_DIV_MIN(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SS(SS), .SCLK(SCLK), .QD_READ(QD_READ),
    .QD_WRITE(QD_WRITE), .QD_WRITE_ENABLE(QD_WRITE_ENABLE),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_FIRST(RX_FIRST),
    .TX_EN(TX_EN), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ),
    .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       first;
    int         at;
  } rx_exp_t;

  typedef struct {
    logic [1:0] qd;
    logic [1:0] oe;
    bit         chk_qd;
  } pair_exp_t;

  rx_exp_t   rx_q[$];
  int        req_q[$];
  pair_exp_t pair_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-level monitor, sampled on the falling CLK edge.
  rx_exp_t re;
  int      rq;
  always @(negedge CLK) begin
    if (RX_VALID !== 1'b0) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=0x%0h required=no RX_VALID (cycle %0d)", RX_DATA, cyc);
      end else begin
        re = rx_q.pop_front();
        chk("rx_data", {24'd0, RX_DATA}, {24'd0, re.data});
        chk("rx_first", {31'd0, RX_FIRST}, {31'd0, re.first});
        chk("rx_latency", cyc, re.at);
      end
    end
    if (TX_REQ !== 1'b0) begin
      if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_req_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        rq = req_q.pop_front();
        chk("tx_req_cycle", cyc, rq);
      end
    end
  end

  // Pad monitor: what the master sees at each SCLK rise.
  pair_exp_t pe_mon;
  always @(posedge SCLK) begin
    if (pair_q.size() != 0) begin
      pe_mon = pair_q.pop_front();
      chk("tx_oe", {30'd0, QD_WRITE_ENABLE}, {30'd0, pe_mon.oe});
      if (pe_mon.chk_qd) chk("tx_pair", {30'd0, QD_WRITE}, {30'd0, pe_mon.qd});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One SCLK period at CLK/8: data set with the fall, rise 4 cycles later.
  task automatic send_pair(input logic [1:0] p, input bit push, input pair_exp_t pe);
    QD_READ = p;
    tick(4);
    if (push) pair_q.push_back(pe);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  // tx_mode: 0 = receiving, 1 = data slot (txb expected on pads),
  // 2 = turnaround slot (pads tri-stated).
  task automatic send_byte(input logic [7:0] rxb, input bit exp_rx, input bit exp_first,
                           input bit exp_req, input int tx_mode, input logic [7:0] txb,
                           input logic [7:0] next_data);
    pair_exp_t pe;
    rx_exp_t   e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        e.data  = rxb;
        e.first = exp_first;
        e.at    = cyc + 8;
        if (exp_rx) rx_q.push_back(e);
        if (exp_req) req_q.push_back(cyc + 8);
      end
      pe.qd     = txb[7-2*i -: 2];
      pe.oe     = (tx_mode == 1) ? 2'b11 : 2'b00;
      pe.chk_qd = (tx_mode == 1);
      send_pair(rxb[7-2*i -: 2], tx_mode != 0, pe);
      if (i == 0 && tx_mode == 1) TX_DATA = next_data;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "tb_dspi_link timeout");
  end

  initial begin
    pair_exp_t pe;
    logic [7:0] b;

    // Reset values.
    tick(3);
    chk("rst_qd_write", {30'd0, QD_WRITE}, 32'd0);
    chk("rst_qd_oe", {30'd0, QD_WRITE_ENABLE}, 32'd0);
    chk("rst_rx_data", {24'd0, RX_DATA}, 32'd0);
    chk("rst_strobes", {29'd0, RX_VALID, RX_FIRST, TX_REQ}, 32'd0);
    chk("rst_busy_ferr", {30'd0, BUSY, FRAME_ERR}, 32'd0);
    RST_N = 1'b1;
    tick(5);

    // Receive 0xA5, 0x3C.
    SS = 1'b0;
    tick(6);
    chk("busy_in_frame", {31'd0, BUSY}, 32'd1);
    send_byte(8'hA5, 1, 1, 0, 0, 8'h00, 8'h00);
    send_byte(8'h3C, 1, 0, 0, 0, 8'h00, 8'h00);
    tick(4);
    SS = 1'b1;
    tick(8);
    chk("rx_ferr_clear", {31'd0, FRAME_ERR}, 32'd0);
    chk("busy_after_frame", {31'd0, BUSY}, 32'd0);

    // Command 0x03 then transmit 0x96, 0x5A.
    TX_EN = 1'b1;
    TX_DATA = 8'h96;
    SS = 1'b0;
    tick(6);
`ifdef DSPI_DUMMY_SLOT_EN
    send_byte(8'h03, 1, 1, 0, 0, 8'h00, 8'h00);
    send_byte(8'h00, 0, 0, 1, 2, 8'h00, 8'h00);
`else
    send_byte(8'h03, 1, 1, 1, 0, 8'h00, 8'h00);
`endif
    send_byte(8'h00, 0, 0, 1, 1, 8'h96, 8'h5A);
    send_byte(8'h00, 0, 0, 1, 1, 8'h5A, 8'h5A);
    tick(4);
    SS = 1'b1;
    tick(3);
    chk("oe_hold_3cyc", {30'd0, QD_WRITE_ENABLE}, 32'd3);
    tick(1);
    chk("oe_release_4cyc", {30'd0, QD_WRITE_ENABLE}, 32'd0);
    TX_EN = 1'b0;
    tick(4);
    chk("tx_ferr_clear", {31'd0, FRAME_ERR}, 32'd0);

    // SS rises after two pairs.
    SS = 1'b0;
    tick(6);
    pe = '{2'b00, 2'b00, 1'b0};
    send_pair(2'b11, 0, pe);
    send_pair(2'b01, 0, pe);
    tick(4);
    SS = 1'b1;
    tick(8);
    chk("ferr_set", {31'd0, FRAME_ERR}, 32'd1);
    tick(20);
    chk("ferr_sticky", {31'd0, FRAME_ERR}, 32'd1);
    SS = 1'b0;
    tick(3);
    chk("ferr_before_fall", {31'd0, FRAME_ERR}, 32'd1);
    tick(1);
    chk("ferr_cleared", {31'd0, FRAME_ERR}, 32'd0);
    tick(4);
    SS = 1'b1;
    tick(8);

    // Reset while transmitting, SS held low across it.
    TX_EN = 1'b1;
    TX_DATA = 8'h96;
    SS = 1'b0;
    tick(6);
`ifdef DSPI_DUMMY_SLOT_EN
    send_byte(8'h03, 1, 1, 0, 0, 8'h00, 8'h00);
    send_byte(8'h00, 0, 0, 1, 2, 8'h00, 8'h00);
`else
    send_byte(8'h03, 1, 1, 1, 0, 8'h00, 8'h00);
`endif
    pe = '{2'b10, 2'b11, 1'b1};
    send_pair(2'b00, 1, pe);
    tick(1);
    chk("oe_before_rst", {30'd0, QD_WRITE_ENABLE}, 32'd3);
    RST_N = 1'b0;
    #1;
    chk("oe_async_rst", {30'd0, QD_WRITE_ENABLE}, 32'd0);
    tick(2);
    RST_N = 1'b1;
    TX_EN = 1'b0;
    tick(4);
    chk("busy_after_rst", {31'd0, BUSY}, 32'd0);
    send_byte(8'hC3, 0, 0, 0, 0, 8'h00, 8'h00);
    tick(8);
    chk("no_frame_after_rst", {31'd0, BUSY}, 32'd0);
    SS = 1'b1;
    tick(8);
    SS = 1'b0;
    tick(6);
    send_byte(8'h5C, 1, 1, 0, 0, 8'h00, 8'h00);
    tick(4);
    SS = 1'b1;
    tick(8);

    // 16 back-to-back random bytes.
    SS = 1'b0;
    tick(6);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1, (i == 0), 0, 0, 8'h00, 8'h00);
    end
    tick(4);
    SS = 1'b1;
    tick(8);
    chk("burst_ferr_clear", {31'd0, FRAME_ERR}, 32'd0);

    tick(4);
    chk("rx_queue_drained", rx_q.size(), 32'd0);
    chk("req_queue_drained", req_q.size(), 32'd0);
    chk("pair_queue_drained", pair_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
